onehot_index_encoder: RTL and testbench
=======================================

# onehot_index_encoder

Sequential bit-mask-to-index encoder: the reverse direction of the 3-to-8 one-hot decoder. It accepts an 8-bit request mask over a valid/ready handshake. It then emits the 3-bit binary index of every set bit, one index per accepted output beat, lowest index first, and flags the final beat. It sits between request-collection logic and any consumer that works on binary indices, such as a decoder feeding select lines.

## Interface
- WIDTH, default 8: mask width; must be a power of two, 2 or greater.
- IDX_W, default $clog2(WIDTH): index width; derived, not overridden.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  mask present on `in`.
- in_ready  out  1  block can accept a mask.
- in  in  WIDTH  request mask.
- out_valid  out  1  `out_idx` holds a valid index.
- out_ready  in  1  consumer accepts the current index.
- out_idx  out  IDX_W  binary index of the selected set bit.
- out_last  out  1  current index is the final set bit of the mask.
- zero_err  out  1  one-cycle pulse: a zero mask was accepted.

## Operation
- Two states: IDLE and EMIT. Internal `pending` register is WIDTH bits.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, `in` is captured into `pending`.
  - Nonzero mask: go to EMIT.
  - Zero mask: stay in IDLE; zero_err=1 for the next cycle only; no output beat is produced.
- EMIT:
  - in_ready=0; masks offered are not accepted.
  - out_valid=1.
  - out_idx = position of the lowest set bit of `pending`.
  - out_last=1 when exactly one bit of `pending` is set.
- Output handshake, out_valid&&out_ready:
  - The selected bit of `pending` is cleared.
  - If out_last=1, go to IDLE.
  - Otherwise stay in EMIT with the next set bit.
- With out_ready=0, out_idx, out_last and `pending` hold exactly.
- out_idx and out_last are combinational from `pending`. They are don't-care only while out_valid=0, and are driven to 0 in IDLE.
- Reset (any state, including mid-burst):
  - pending=0, state=IDLE.
  - Registered outputs: out_valid=0, zero_err=0.
  - Outputs in effect after reset: out_idx=0, out_last=0, in_ready=1.
  - The interrupted mask is discarded, not resumed.

## Timing
- Input accept at edge T: first out_valid=1 from T+1 (latency 1 cycle).
- Throughput: one index per cycle while out_ready=1. A mask with N set bits occupies EMIT for exactly N cycles under no backpressure.
- Last beat accepted at edge E: in_ready=1 from E+1. The next mask can be captured at E+1, giving one bubble cycle between bursts.
- in_ready and in_valid are independent; in_ready does not depend combinationally on in_valid.
- out_valid is never deasserted without a handshake, except by reset.
- zero_err is asserted the cycle after capture and cleared the cycle after that.

## Configuration
- Macro ONEHOT_ENC_MSB_FIRST_EN.
- Defined: selection is the highest set bit of `pending`; indices are emitted in descending order. out_last semantics are unchanged.
- Undefined (default): lowest set bit first, ascending order.
- No port or latency changes in either build.

## Test plan
- in=8'b0010_0110, out_ready=1 throughout:
  - Indices 1, 2, 5 on three consecutive cycles starting at T+1.
  - out_last=1 only with index 5.
  - in_ready=1 at the cycle after index 5.
- in=8'hFF, out_ready=1:
  - Indices 0..7 on eight consecutive cycles; in_ready=0 for all eight.
  - A second mask held on in_valid during the burst is captured only after index 7.
- in=8'b1001_0000; out_ready=0 for 3 cycles, then 1:
  - out_idx=4 is held stable for 4 cycles, then 7 with out_last=1.
- in=8'h00:
  - zero_err=1 for exactly one cycle at T+1; out_valid stays 0; in_ready stays 1.
- in=8'hA5; assert rst for one cycle after two indices (0, 2) are accepted:
  - Next cycle: out_valid=0, in_ready=1.
  - A new mask 8'h08 then yields a single index 3 with out_last=1.
- ONEHOT_ENC_MSB_FIRST_EN build, in=8'b0010_0110:
  - Indices 5, 2, 1; out_last with index 1.

Source files
------------

// File: rtl/onehot_index_encoder.sv
//------------------------------------------------------------------------------
// Module      : onehot_index_encoder
// Description : Accepts a WIDTH-bit request mask over a valid/ready handshake
//               and emits the binary index of every set bit, one index per
//               accepted output beat, flagging the final beat with out_last.
//               A zero mask is absorbed and reported with a one-cycle
//               zero_err pulse.
//               Optional build macro: ONEHOT_ENC_MSB_FIRST_EN
//                 undefined : lowest set bit first (ascending indices)
//                 defined   : highest set bit first (descending indices)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module onehot_index_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err
);

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [WIDTH-1:0] w_sel;
  logic [IDX_W-1:0] w_idx;
  logic             w_single;
  logic             r_zero_err;
  logic             w_zero_err_nxt;
  logic             w_emit;

  // Priority select of the next bit to emit; the last match in loop order wins,
  // so the loop direction decides which end of the mask has priority.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (r_pending[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_idx    = IDX_W'(i);
      end
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_idx    = IDX_W'(i);
      end
    end
`endif
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign w_single = (r_pending != '0) && ((r_pending & (r_pending - c_ONE)) == '0);

  assign w_emit    = (r_state == S_EMIT);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = w_emit;
  assign out_idx   = w_emit ? w_idx : '0;
  assign out_last  = w_emit & w_single;
  assign zero_err  = r_zero_err;

  // Next-state and pending-mask update for both handshakes.
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_zero_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_pending_nxt = in;
          if (in != '0) begin
            w_state_nxt = S_EMIT;
          end else begin
            w_zero_err_nxt = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          w_pending_nxt = r_pending & ~w_sel;
          if (w_single) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  // State, pending mask and zero-mask pulse registers; reset discards any burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_zero_err <= w_zero_err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_onehot_index_encoder.sv
//------------------------------------------------------------------------------
// Module      : tb_onehot_index_encoder
// Description : Directed self-checking bench for onehot_index_encoder.
//               Honours ONEHOT_ENC_MSB_FIRST_EN for expected index order.
// Revision    : 1.1 - explicit comparisons
//------------------------------------------------------------------------------
`default_nettype none

module tb_onehot_index_encoder;

`ifdef ONEHOT_ENC_MSB_FIRST_EN
    localparam bit c_MSB = 1'b1;
`else
    localparam bit c_MSB = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_err;

    int checks;
    int failures;

    onehot_index_encoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_err  (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, then settle past the edge before checking/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic report(input string tag, input int obs, input int exp);
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Expected state of all outputs in IDLE.
    task automatic chk_idle(input string tag);
        checks += 4;
        if (out_valid !== 1'b0) report({tag, " out_valid"}, out_valid, 0);
        if (in_ready  !== 1'b1) report({tag, " in_ready"},  in_ready,  1);
        if (out_idx   !== 3'd0) report({tag, " out_idx"},   out_idx,   0);
        if (out_last  !== 1'b0) report({tag, " out_last"},  out_last,  0);
    endtask

    // Expected state of all outputs while emitting a given index.
    task automatic chk_beat(input string tag, input logic [2:0] idx, input logic last);
        checks += 4;
        if (out_valid !== 1'b1) report({tag, " out_valid"}, out_valid, 1);
        if (in_ready  !== 1'b0) report({tag, " in_ready"},  in_ready,  0);
        if (out_idx   !== idx)  report({tag, " out_idx"},   out_idx,   idx);
        if (out_last  !== last) report({tag, " out_last"},  out_last,  last);
    endtask

    initial begin
        logic [2:0] exp_a [3];
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in        = 8'h00;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        checks++;
        if (zero_err !== 1'b0) report("reset zero_err", zero_err, 0);
        rst = 1'b0;
        tick();
        chk_idle("post_reset");

        // Mask 0010_0110, no backpressure
        if (c_MSB) begin
            exp_a[0] = 3'd5; exp_a[1] = 3'd2; exp_a[2] = 3'd1;
        end else begin
            exp_a[0] = 3'd1; exp_a[1] = 3'd2; exp_a[2] = 3'd5;
        end
        in        = 8'b0010_0110;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in       = 8'h00;
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (out_valid !== 1'b1)     report("m26 out_valid", out_valid, 1);
            if (out_idx   !== exp_a[k]) report("m26 out_idx",   out_idx,   exp_a[k]);
            if (out_last  !== (k == 2)) report("m26 out_last",  out_last,  (k == 2));
            tick();
        end
        chk_idle("m26 done");

        // Mask FF with a second mask held on the input during the burst
        in       = 8'hFF;
        in_valid = 1'b1;
        tick();
        in = 8'h81;
        for (int k = 0; k < 8; k++) begin
            chk_beat("mFF beat", c_MSB ? 3'(7 - k) : 3'(k), k == 7);
            tick();
        end
        chk_idle("mFF gap");
        tick();
        in_valid = 1'b0;
        in       = 8'h00;
        chk_beat("m81 b0", c_MSB ? 3'd7 : 3'd0, 1'b0);
        tick();
        chk_beat("m81 b1", c_MSB ? 3'd0 : 3'd7, 1'b1);
        tick();
        chk_idle("m81 done");

        // Mask 1001_0000 with 3 cycles of backpressure
        in        = 8'b1001_0000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in       = 8'h00;
        for (int k = 0; k < 4; k++) begin
            chk_beat("m90 hold", c_MSB ? 3'd7 : 3'd4, 1'b0);
            out_ready = (k == 3);
            tick();
        end
        chk_beat("m90 last", c_MSB ? 3'd4 : 3'd7, 1'b1);
        tick();
        chk_idle("m90 done");

        // Zero mask
        in       = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_idle("zero T+1");
        checks++;
        if (zero_err !== 1'b1) report("zero pulse", zero_err, 1);
        tick();
        chk_idle("zero T+2");
        checks++;
        if (zero_err !== 1'b0) report("zero clear", zero_err, 0);

        // Mask A5 interrupted by reset after two beats
        in       = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in       = 8'h00;
        chk_beat("mA5 b0", c_MSB ? 3'd7 : 3'd0, 1'b0);
        tick();
        chk_beat("mA5 b1", c_MSB ? 3'd5 : 3'd2, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("mA5 reset");
        checks++;
        if (zero_err !== 1'b0) report("mA5 reset zero_err", zero_err, 0);
        in       = 8'h08;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in       = 8'h00;
        chk_beat("m08 b0", 3'd3, 1'b1);
        tick();
        chk_idle("m08 done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
